fifo_gray_ptr: RTL and testbench

Parametrised pointer controller for one side of the asynchronous FIFO. It keeps a binary read or write pointer with an extra wrap bit, and publishes the pointer as registered Gray code for the opposite clock domain. It synchronises the opposite domain's Gray pointer into its own clock, converts it back to binary, and produces the registered full (write side) or empty (read side) flag plus an occupancy count. One instance sits in the write clock domain and one in the read clock domain of each FIFO.

---
 rtl/fifo_gray_ptr.sv | 150 +++++++++++++++
 tb/tb_fifo_gray_ptr.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_gray_ptr.sv
// fifo_gray_ptr: one side of an asynchronous FIFO pointer pair.
//
// It keeps a binary pointer with an extra wrap bit, publishes it as a registered
// Gray pointer for the other clock domain, synchronises the remote Gray pointer,
// and produces a registered full (MODE 0) or empty (MODE 1) flag and an occupancy
// level as seen from this domain.
//
// Parameters:
//   ADDR_W      address width, depth = 2**ADDR_W, pointer width PW = ADDR_W+1
//   MODE        0 = write side (flag = full), 1 = read side (flag = empty)
//   SYNC_STAGES flops in the remote pointer synchroniser (>= 2)
//   ALMOST_TH   almost-flag threshold (only with FIFO_GRAY_PTR_ALMOST_EN)
//
// Ports:
//   clk          local clock, rising edge
//   rst_n        synchronous active-low reset
//   inc          push (MODE 0) or pop (MODE 1) request, ignored while flag is set
//   remote_gray  Gray pointer from the other domain (asynchronous)
//   addr         RAM address, low ADDR_W bits of the binary pointer
//   gray_ptr     registered Gray pointer for the other domain
//   flag         registered full (MODE 0) / empty (MODE 1)
//   level        occupancy, 0..2**ADDR_W, combinational from registered state
//   almost       almost-full / almost-empty
//
// Build option: define FIFO_GRAY_PTR_ALMOST_EN to generate the registered almost
// flag; otherwise almost is tied to 0.

module fifo_gray_ptr #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned MODE        = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ALMOST_TH   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic [ADDR_W:0]   remote_gray,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   gray_ptr,
  output logic              flag,
  output logic [ADDR_W:0]   level,
  output logic              almost
);

  localparam int unsigned PW = ADDR_W + 1;

  // The read side comes out of reset empty; the write side is not full.
  localparam logic FLAG_RST = (MODE == 1) ? 1'b1 : 1'b0;

  // Full when the remote pointer equals ours with the two top Gray bits inverted,
  // i.e. the binary pointers differ by exactly the depth.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] bin_q, bin_next;
  logic [PW-1:0] gray_q, gray_next;
  logic          flag_q, flag_next;
  logic          accept;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rg_s, rb_s;

  assign accept    = inc & ~flag_q;
  assign bin_next  = bin_q + {{ADDR_W{1'b0}}, accept};
  assign gray_next = bin_next ^ (bin_next >> 1);

  assign rg_s = sync_q[SYNC_STAGES-1];
  assign rb_s = gray2bin(rg_s);

  // The flag is evaluated against the post-accept pointer and the current
  // synchronised remote pointer, so it asserts on the filling/emptying edge and
  // clears as soon as the remote move is visible, regardless of its old value.
  always_comb begin
    flag_next = 1'b0;
    level     = '0;
    if (MODE == 0) begin
      flag_next = (gray_next == (rg_s ^ FULL_MASK));
      level     = bin_q - rb_s;
    end else begin
      flag_next = (gray_next == rg_s);
      level     = rb_s - bin_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      flag_q <= FLAG_RST;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      bin_q     <= bin_next;
      gray_q    <= gray_next;
      flag_q    <= flag_next;
      sync_q[0] <= remote_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign addr     = bin_q[ADDR_W-1:0];
  assign gray_ptr = gray_q;
  assign flag     = flag_q;

`ifdef FIFO_GRAY_PTR_ALMOST_EN
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic          almost_q, almost_d;
  logic [PW-1:0] rb_next, level_next;

  // Use the level exactly as it will appear after this edge: the new local
  // pointer and the remote value about to reach the last synchroniser stage.
  assign rb_next = gray2bin(sync_q[SYNC_STAGES-2]);

  always_comb begin
    level_next = '0;
    almost_d   = 1'b0;
    if (MODE == 0) begin
      level_next = bin_next - rb_next;
      almost_d   = (32'(level_next) >= (DEPTH - ALMOST_TH));
    end else begin
      level_next = rb_next - bin_next;
      almost_d   = (32'(level_next) <= ALMOST_TH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost_q <= FLAG_RST;
    end else begin
      almost_q <= almost_d;
    end
  end

  assign almost = almost_q;
`else
  assign almost = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_gray_ptr.sv
// Testbench for fifo_gray_ptr: one write-side and one read-side instance
// (ADDR_W=2, SYNC_STAGES=2, ALMOST_TH=1) checked against a pointer-count model.

module tb_fifo_gray_ptr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inc0, inc1;
  logic [2:0] rg0, rg1;
  logic [1:0] addr0, addr1;
  logic [2:0] gp0, gp1, lvl0, lvl1;
  logic       flag0, flag1, alm0, alm1;

  fifo_gray_ptr #(.ADDR_W(2), .MODE(0), .SYNC_STAGES(2), .ALMOST_TH(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .inc(inc0), .remote_gray(rg0), .addr(addr0),
    .gray_ptr(gp0), .flag(flag0), .level(lvl0), .almost(alm0)
  );

  fifo_gray_ptr #(.ADDR_W(2), .MODE(1), .SYNC_STAGES(2), .ALMOST_TH(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .inc(inc1), .remote_gray(rg1), .addr(addr1),
    .gray_ptr(gp1), .flag(flag1), .level(lvl1), .almost(alm1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: pointer counts mod 8, remote binary pointer history, flags.
  int m_ptr [2];
  int m_r1  [2];
  int m_r2  [2];
  bit m_flag[2];
  int rem   [2];
  int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_level(input int s);
    if (s == 0) return (m_ptr[0] - m_r2[0]) & 7;
    return (m_r2[1] - m_ptr[1]) & 7;
  endfunction

  task automatic check_all();
    int lv0, lv1;
    bit a0, a1;
    lv0 = m_level(0);
    lv1 = m_level(1);
`ifdef FIFO_GRAY_PTR_ALMOST_EN
    a0 = (lv0 >= 3);
    a1 = (lv1 <= 1);
`else
    a0 = 1'b0;
    a1 = 1'b0;
`endif
    chk("w_addr", 32'(addr0), 32'(m_ptr[0] % 4));
    chk("w_gray", 32'(gp0), 32'(gray_tab[m_ptr[0]]));
    chk("w_flag", 32'(flag0), 32'(m_flag[0]));
    chk("w_level", 32'(lvl0), 32'(lv0));
    chk("w_almost", 32'(alm0), 32'(a0));
    chk("r_addr", 32'(addr1), 32'(m_ptr[1] % 4));
    chk("r_gray", 32'(gp1), 32'(gray_tab[m_ptr[1]]));
    chk("r_flag", 32'(flag1), 32'(m_flag[1]));
    chk("r_level", 32'(lvl1), 32'(lv1));
    chk("r_almost", 32'(alm1), 32'(a1));
  endtask

  // Called at a falling edge: drive, take one rising edge, update model, check.
  task automatic edge_step(input bit i0, input bit i1, input bit rst);
    bit inc_s, acc;
    int pn;
    bit fn;
    rst_n = rst;
    inc0  = i0;
    inc1  = i1;
    rg0   = 3'(gray_tab[rem[0]]);
    rg1   = 3'(gray_tab[rem[1]]);
    @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      inc_s = (s == 0) ? i0 : i1;
      if (!rst) begin
        m_ptr[s]  = 0;
        m_r1[s]   = 0;
        m_r2[s]   = 0;
        m_flag[s] = (s == 1);
      end else begin
        acc = inc_s && !m_flag[s];
        pn  = (m_ptr[s] + int'(acc)) % 8;
        if (s == 0) fn = (((pn - m_r2[s]) & 7) == 4);
        else        fn = (pn == m_r2[s]);
        m_r2[s]   = m_r1[s];
        m_r1[s]   = rem[s];
        m_ptr[s]  = pn;
        m_flag[s] = fn;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    inc0  = 1'b0;
    inc1  = 1'b0;
    rg0   = '0;
    rg1   = '0;
    rem[0] = 0;
    rem[1] = 0;
    @(negedge clk);

    // Reset held for two edges with inc high.
    edge_step(1, 1, 0);
    edge_step(1, 1, 0);
    chk("rst_w_addr", 32'(addr0), 0);
    chk("rst_w_gray", 32'(gp0), 0);
    chk("rst_w_flag", 32'(flag0), 0);
    chk("rst_r_flag", 32'(flag1), 1);
    chk("rst_r_level", 32'(lvl1), 0);

    // Write side fill: six pushes, the last two ignored.
    for (int i = 0; i < 6; i++) begin
      edge_step(1, 0, 1);
      if (i == 3) begin
        chk("fill_flag4", 32'(flag0), 1);
        chk("fill_addr4", 32'(addr0), 0);
      end
    end
    chk("fill_gray_hold", 32'(gp0), 32'(3'b110));
    chk("fill_level", 32'(lvl0), 4);

    // Drain visibility: remote read pointer advances by one.
    rem[0] = 1;
    edge_step(0, 0, 1);
    edge_step(0, 0, 1);
    chk("drain_level", 32'(lvl0), 3);
    edge_step(0, 0, 1);
    chk("drain_flag", 32'(flag0), 0);
    edge_step(1, 0, 1);
    chk("refill_flag", 32'(flag0), 1);
    chk("refill_addr", 32'(addr0), 1);

    // Read side: remote write pointer at 4 (Gray 110).
    rem[1] = 4;
    edge_step(0, 0, 1);
    edge_step(0, 0, 1);
    chk("rd_level", 32'(lvl1), 4);
    edge_step(0, 0, 1);
    chk("rd_flag_clear", 32'(flag1), 0);
    for (int i = 0; i < 4; i++) begin
      edge_step(0, 1, 1);
      chk("rd_addr", 32'(addr1), 32'((i + 1) % 4));
    end
    chk("rd_empty", 32'(flag1), 1);
    edge_step(0, 1, 1);
    chk("rd_pop5_addr", 32'(addr1), 0);
    chk("rd_pop5_gray", 32'(gp1), 32'(3'b110));

    // Reset in mid-operation with a nonzero synchroniser.
    rem[0] = 0;
    rem[1] = 0;
    edge_step(0, 0, 0);
    rem[0] = 1;
    for (int i = 0; i < 3; i++) edge_step(1, 0, 1);
    chk("mid_addr", 32'(addr0), 3);
    rem[0] = 0;
    edge_step(1, 0, 0);
    chk("mid_rst_addr", 32'(addr0), 0);
    chk("mid_rst_gray", 32'(gp0), 0);
    chk("mid_rst_flag", 32'(flag0), 0);
    chk("mid_rst_level", 32'(lvl0), 0);

    // Randomised traffic with a well-behaved remote pointer.
    for (int i = 0; i < 800; i++) begin
      if ($urandom % 64 == 0) begin
        rem[0] = 0;
        rem[1] = 0;
        edge_step(1'($urandom), 1'($urandom), 1'b0);
      end else begin
        if (rem[0] != m_ptr[0] && ($urandom % 2 == 1)) rem[0] = (rem[0] + 1) % 8;
        if (((rem[1] - m_ptr[1]) & 7) < 4 && ($urandom % 2 == 1)) rem[1] = (rem[1] + 1) % 8;
        edge_step(1'($urandom), 1'($urandom), 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
